// File: rtl/fpga_computer.sv
// SAP-1-class 8-bit computer: shared bus, 16x8 RAM, A/B/ALU, OUT, 6-state run controller
// and an external programming path used while GO is low.
module fpga_computer #(
    parameter int RAM_DEPTH = 16,
    parameter int T_STATES  = 6
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] SEL,
    input  logic [7:0] PRGM_IN,
    input  logic       PRGM,
    input  logic       OE,
    input  logic       WE,
    input  logic       EN,
    input  logic       GO,
    input  logic       HLT,
    output logic [7:0] BUS_OUT,
    output logic [7:0] CURRENT
);

    localparam logic [2:0] T1 = 3'd0;
    localparam logic [2:0] T2 = 3'd1;
    localparam logic [2:0] T3 = 3'd2;
    localparam logic [2:0] T4 = 3'd3;
    localparam logic [2:0] T5 = 3'd4;
    localparam logic [2:0] T6 = 3'(T_STATES - 1);

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [3:0] pc_q, pc_d, mar_q, mar_d;
    logic [7:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d, pdr_q, pdr_d;
    logic       c_q, c_d, z_q, z_d, halted_q, halted_d;
    logic [2:0] t_q, t_d;

    logic [7:0] ram_q [RAM_DEPTH];
    logic       ram_we_s;
    logic [7:0] ram_wdata_s;
    logic [7:0] ram_rd_s;

    logic [3:0] opcode_s;
    logic       is_sub_s, is_arith_s, is_mem_op_s, freeze_s;
    logic [8:0] alu_sum_s;
    logic [7:0] alu_res_s, current_s, bus_s;

    assign ram_rd_s    = ram_q[mar_q];
    assign opcode_s    = ir_q[7:4];
    assign is_sub_s    = (opcode_s == OP_SUB);
    assign is_arith_s  = (opcode_s == OP_ADD) || is_sub_s;
    assign is_mem_op_s = (opcode_s == OP_LDA) || is_arith_s;
    assign freeze_s    = halted_q || HLT;

    // Subtract is A + ~B + 1, so the carry out reads as "no borrow".
    assign alu_sum_s = {1'b0, a_q} + {1'b0, (is_sub_s ? ~b_q : b_q)} + {8'h00, is_sub_s};
    assign alu_res_s = alu_sum_s[7:0];

    // Debug register view selected by SEL.
    always_comb begin
        current_s = 8'h00;
        case (SEL)
            4'h0:    current_s = {4'h0, pc_q};
            4'h1:    current_s = a_q;
            4'h2:    current_s = b_q;
            4'h3:    current_s = alu_res_s;
            4'h4:    current_s = {4'h0, mar_q};
            4'h5:    current_s = ram_rd_s;
            4'h6:    current_s = ir_q;
            4'h7:    current_s = out_q;
            4'h8:    current_s = {halted_q, c_q, z_q, 2'b00, t_q};
            default: current_s = 8'h00;
        endcase
    end

    // Bus source: programmer path in manual mode, active transfer in run mode.
    always_comb begin
        bus_s = 8'h00;
        if (!GO) begin
            if (PRGM) begin
                bus_s = PRGM_IN;
            end else if (OE) begin
                bus_s = pdr_q;
            end else begin
                bus_s = current_s;
            end
        end else begin
            case (t_q)
                T1:      bus_s = {4'h0, pc_q};
                T2:      bus_s = ram_rd_s;
                T3:      bus_s = is_mem_op_s ? {4'h0, ir_q[3:0]} : ((opcode_s == OP_OUT) ? a_q : 8'h00);
                T4:      bus_s = is_mem_op_s ? ram_rd_s : 8'h00;
                T5:      bus_s = is_arith_s ? alu_res_s : 8'h00;
                default: bus_s = 8'h00;
            endcase
        end
    end

    assign BUS_OUT = RESET ? 8'h00 : bus_s;
    assign CURRENT = RESET ? 8'h00 : current_s;

    // Next-state for every register and the RAM write port.
    always_comb begin
        pc_d = pc_q;  mar_d = mar_q;  ir_d = ir_q;  a_d = a_q;  b_d = b_q;
        out_d = out_q;  pdr_d = pdr_q;  c_d = c_q;  z_d = z_q;
        halted_d = halted_q;  t_d = t_q;
        ram_we_s = 1'b0;  ram_wdata_s = 8'h00;
        if (!freeze_s) begin
            if (PRGM) begin
                pdr_d = PRGM_IN;
            end else begin
                pdr_d = pdr_q;
            end
            if (!GO) begin
                t_d = T1;
                if (EN) begin
                    pc_d = pc_q + 4'd1;
                end else begin
                    pc_d = pc_q;
                end
                // WE writes through the current MAR; an explicit RAM load overrides it.
                if (WE) begin
                    ram_we_s    = 1'b1;
                    ram_wdata_s = pdr_q;
                end else begin
                    ram_we_s = 1'b0;
                end
                if (PRGM && OE) begin
                    case (SEL)
                        4'h0: pc_d  = bus_s[3:0];
                        4'h1: a_d   = bus_s;
                        4'h2: b_d   = bus_s;
                        4'h4: mar_d = bus_s[3:0];
                        4'h5: begin
                            ram_we_s    = 1'b1;
                            ram_wdata_s = bus_s;
                        end
                        4'h6: ir_d  = bus_s;
                        4'h7: out_d = bus_s;
                        default: ;
                    endcase
                end else begin
                    a_d = a_q;
                end
            end else begin
                t_d = (t_q >= T6) ? T1 : t_q + 3'd1;
                case (t_q)
                    T1: mar_d = pc_q;
                    T2: begin
                        ir_d = ram_rd_s;
                        pc_d = pc_q + 4'd1;
                    end
                    T3: begin
                        if (is_mem_op_s) begin
                            mar_d = ir_q[3:0];
                        end else if (opcode_s == OP_OUT) begin
                            out_d = a_q;
                        end else if (opcode_s == OP_HLT) begin
                            halted_d = 1'b1;
                        end else begin
                            halted_d = halted_q;
                        end
                    end
                    T4: begin
                        if (opcode_s == OP_LDA) begin
                            a_d = ram_rd_s;
                        end else if (is_arith_s) begin
                            b_d = ram_rd_s;
                        end else begin
                            b_d = b_q;
                        end
                    end
                    T5: begin
                        if (is_arith_s) begin
                            a_d = alu_res_s;
                            c_d = alu_sum_s[8];
                            z_d = (alu_res_s == 8'h00);
                        end else begin
                            a_d = a_q;
                        end
                    end
                    default: ;
                endcase
            end
        end else begin
            t_d = t_q;
        end
    end

    // Architectural registers; RAM is deliberately outside the reset domain.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q <= 4'h0;  mar_q <= 4'h0;  ir_q <= 8'h00;  a_q <= 8'h00;
            b_q <= 8'h00;  out_q <= 8'h00;  pdr_q <= 8'h00;  c_q <= 1'b0;
            z_q <= 1'b0;  halted_q <= 1'b0;  t_q <= T1;
        end else begin
            pc_q <= pc_d;  mar_q <= mar_d;  ir_q <= ir_d;  a_q <= a_d;
            b_q <= b_d;  out_q <= out_d;  pdr_q <= pdr_d;  c_q <= c_d;
            z_q <= z_d;  halted_q <= halted_d;  t_q <= t_d;
        end
    end

    // RAM write port.
    always_ff @(posedge CLK) begin
        if (ram_we_s && !RESET) begin
            ram_q[mar_q] <= ram_wdata_s;
        end
    end

endmodule

// File: tb/tb_fpga_computer.sv
// Directed bench for fpga_computer: stimulus queues expected CURRENT/BUS_OUT values,
// a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_fpga_computer;

    logic       CLK = 1'b0;
    logic       RESET, PRGM, OE, WE, EN, GO, HLT;
    logic [3:0] SEL;
    logic [7:0] PRGM_IN, BUS_OUT, CURRENT;

    typedef struct {
        string      name;
        logic       use_bus;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t cur_e;
    logic [7:0] act;
    int total = 0;
    int bad   = 0;

    fpga_computer dut (
        .CLK(CLK), .RESET(RESET), .SEL(SEL), .PRGM_IN(PRGM_IN), .PRGM(PRGM),
        .OE(OE), .WE(WE), .EN(EN), .GO(GO), .HLT(HLT),
        .BUS_OUT(BUS_OUT), .CURRENT(CURRENT)
    );

    always #5 CLK = ~CLK;

    // Monitor: compare one queued expectation per falling edge.
    always @(negedge CLK) begin
        if (sb.size() != 0) begin
            cur_e = sb.pop_front();
            act   = cur_e.use_bus ? BUS_OUT : CURRENT;
            total++;
            if (act !== cur_e.exp) begin
                bad++;
                $display("FAIL %s: got %02h want %02h", cur_e.name, act, cur_e.exp);
            end
        end
    end

    task automatic clk(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] sel, input logic use_bus,
                         input logic [7:0] exp);
        exp_t e;
        SEL       = sel;
        e.name    = nm;
        e.use_bus = use_bus;
        e.exp     = exp;
        sb.push_back(e);
        for (int k = 0; k < 40 && sb.size() != 0; k++) #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: monitor timeout, want %02h", nm, exp);
            sb.delete();
        end
    endtask

    task automatic write_ram(input logic [3:0] addr, input logic [7:0] data);
        SEL = 4'h4; PRGM = 1'b1; OE = 1'b1; PRGM_IN = {4'h0, addr};
        clk(1);
        SEL = 4'h5; PRGM_IN = data;
        clk(1);
        PRGM = 1'b0; OE = 1'b0;
    endtask

    task automatic pulse_reset;
        RESET = 1'b1;
        clk(1);
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; PRGM = 1'b0; OE = 1'b0; WE = 1'b0; EN = 1'b0;
        GO = 1'b0; HLT = 1'b0; SEL = 4'h0; PRGM_IN = 8'h00;
        clk(2);
        RESET = 1'b0;
        check("rst_pc",   4'h0, 1'b0, 8'h00);
        check("rst_stat", 4'h8, 1'b0, 8'h00);
        check("rst_a",    4'h1, 1'b0, 8'h00);

        // Manual MAR load, then RAM write through PDR
        SEL = 4'h4; PRGM = 1'b1; OE = 1'b1; PRGM_IN = 8'h53;
        clk(1);
        check("mar_load",  4'h4, 1'b0, 8'h03);
        check("bus_prgm",  4'h4, 1'b1, 8'h53);
        OE = 1'b0; PRGM_IN = 8'hA0;
        clk(1);
        PRGM = 1'b0; WE = 1'b1;
        clk(1);
        WE = 1'b0;
        check("ram_we",    4'h5, 1'b0, 8'hA0);
        check("bus_cur",   4'h4, 1'b1, 8'h03);
        OE = 1'b1;
        check("bus_pdr",   4'h5, 1'b1, 8'hA0);
        OE = 1'b0;

        SEL = 4'h1; PRGM = 1'b1; OE = 1'b1; PRGM_IN = 8'h77;
        clk(1);
        PRGM = 1'b0; OE = 1'b0;
        check("a_load",    4'h1, 1'b0, 8'h77);

        // Asynchronous reset between edges
        RESET = 1'b1;
        check("rstmid_pc",  4'h0, 1'b0, 8'h00);
        check("rstmid_a",   4'h1, 1'b0, 8'h00);
        check("rstmid_mar", 4'h4, 1'b0, 8'h00);
        check("rstmid_out", 4'h7, 1'b0, 8'h00);
        check("rstmid_bus", 4'h5, 1'b1, 8'h00);
        RESET = 1'b0;
        check("post_rst_stat", 4'h8, 1'b0, 8'h00);
        check("post_rst_a",    4'h1, 1'b0, 8'h00);

        SEL = 4'h4; PRGM = 1'b1; OE = 1'b1; PRGM_IN = 8'h03;
        clk(1);
        PRGM = 1'b0; OE = 1'b0;
        check("ram_keep",  4'h5, 1'b0, 8'hA0);

        // PC wraps 15 -> 0
        EN = 1'b1;
        clk(17);
        EN = 1'b0;
        check("pc_wrap",   4'h0, 1'b0, 8'h01);

        // Program: LDA 9, ADD 10, SUB 11, OUT, HLT -> 5+7-2
        pulse_reset();
        write_ram(4'd0, 8'h09);  write_ram(4'd1, 8'h1A);  write_ram(4'd2, 8'h2B);
        write_ram(4'd3, 8'hE0);  write_ram(4'd4, 8'hF0);  write_ram(4'd9, 8'h05);
        write_ram(4'd10, 8'h07); write_ram(4'd11, 8'h02);
        GO = 1'b1;
        clk(40);
        check("prog_out",  4'h7, 1'b0, 8'h0A);
        check("prog_a",    4'h1, 1'b0, 8'h0A);
        check("prog_stat", 4'h8, 1'b0, 8'hC3);
        check("prog_pc",   4'h0, 1'b0, 8'h05);
        check("prog_bus",  4'h0, 1'b1, 8'h00);
        clk(20);
        check("frozen_pc",   4'h0, 1'b0, 8'h05);
        check("frozen_stat", 4'h8, 1'b0, 8'hC3);
        GO = 1'b0;

        // ALU edges: 0xFF+0x01 then 0x00-0x01, with an external HLT mid-SUB
        pulse_reset();
        write_ram(4'd0, 8'h19); write_ram(4'd1, 8'h29);
        write_ram(4'd2, 8'hF0); write_ram(4'd9, 8'h01);
        SEL = 4'h1; PRGM = 1'b1; OE = 1'b1; PRGM_IN = 8'hFF;
        clk(1);
        PRGM = 1'b0; OE = 1'b0;
        check("alu_a_init", 4'h1, 1'b0, 8'hFF);
        GO = 1'b1;
        clk(6);
        GO = 1'b0;
        check("add_a",    4'h1, 1'b0, 8'h00);
        check("add_stat", 4'h8, 1'b0, 8'h60);
        check("add_b",    4'h2, 1'b0, 8'h01);
        GO = 1'b1;
        clk(2);
        HLT = 1'b1;
        check("hlt_t0",   4'h8, 1'b0, 8'h62);
        clk(3);
        check("hlt_t1",   4'h8, 1'b0, 8'h62);
        check("hlt_a",    4'h1, 1'b0, 8'h00);
        HLT = 1'b0;
        clk(4);
        GO = 1'b0;
        check("sub_a",    4'h1, 1'b0, 8'hFF);
        check("sub_stat", 4'h8, 1'b0, 8'h00);
        check("alu_view", 4'h3, 1'b0, 8'hFE);
        GO = 1'b1;
        clk(12);
        check("hlt2_stat", 4'h8, 1'b0, 8'h83);
        check("hlt2_pc",   4'h0, 1'b0, 8'h03);
        GO = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
